// File: rtl/seg_reader_if.sv
// Bus bundle between a multiplexed 7-segment source and seg_reader.
// Optional decimal-point lanes exist only when SEG_READER_DP_EN is defined.
interface seg_reader_if #(
  parameter int unsigned DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   n_dig;
  logic                err_clr;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   valid;
  logic                upd;
  logic [2:0]          upd_idx;
  logic                err;
`ifdef SEG_READER_DP_EN
  logic                seg_dp;
  logic [DIGITS-1:0]   dp;

  modport master (
    output seg_in, n_dig, err_clr, seg_dp,
    input  value, valid, upd, upd_idx, err, dp
  );
  modport slave (
    input  seg_in, n_dig, err_clr, seg_dp,
    output value, valid, upd, upd_idx, err, dp
  );
`else
  modport master (
    output seg_in, n_dig, err_clr,
    input  value, valid, upd, upd_idx, err
  );
  modport slave (
    input  seg_in, n_dig, err_clr,
    output value, valid, upd, upd_idx, err
  );
`endif
endinterface

// File: rtl/seg_reader.sv
// seg_reader: samples a scanned 7-segment bus and recovers one hex nibble per digit.
// A {digit-select, segments} pair commits once it has been sampled STABLE times in a row.
// Optional feature macro: SEG_READER_DP_EN (adds the decimal-point lane and dp outputs).
module seg_reader #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 3
) (
  input logic         clk,
  input logic         n_rst,
  seg_reader_if.slave bus
);

  localparam int unsigned CW = $clog2(STABLE + 1);
`ifdef SEG_READER_DP_EN
  localparam int unsigned PW = 8;
`else
  localparam int unsigned PW = 7;
`endif
  localparam int unsigned   SW      = DIGITS + PW;
  localparam logic [SW-1:0] SMP_RST = {{DIGITS{1'b1}}, {PW{1'b0}}};
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE - 1);

  // Segment pattern to {legal, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h7E:   seg_decode = {1'b1, 4'h0};
      7'h30:   seg_decode = {1'b1, 4'h1};
      7'h6D:   seg_decode = {1'b1, 4'h2};
      7'h79:   seg_decode = {1'b1, 4'h3};
      7'h33:   seg_decode = {1'b1, 4'h4};
      7'h5B:   seg_decode = {1'b1, 4'h5};
      7'h5F:   seg_decode = {1'b1, 4'h6};
      7'h70:   seg_decode = {1'b1, 4'h7};
      7'h7F:   seg_decode = {1'b1, 4'h8};
      7'h7B:   seg_decode = {1'b1, 4'h9};
      7'h77:   seg_decode = {1'b1, 4'hA};
      7'h1F:   seg_decode = {1'b1, 4'hB};
      7'h0D:   seg_decode = {1'b1, 4'hC};
      7'h3D:   seg_decode = {1'b1, 4'hD};
      7'h6F:   seg_decode = {1'b1, 4'hE};
      7'h47:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = 5'h00;
    endcase
  endfunction

  logic [SW-1:0] smp_d, smp_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          hit_d, hit_q;

`ifdef SEG_READER_DP_EN
  assign smp_d = {bus.n_dig, bus.seg_dp, bus.seg_in};
`else
  assign smp_d = {bus.n_dig, bus.seg_in};
`endif

  // Run-length counter; hit marks the edge where the run first reaches STABLE.
  always_comb begin
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (smp_d == smp_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
        hit_d = (cnt_q == CNT_PRE);
      end
    end else begin
      cnt_d = CW'(1);
    end
  end

  // Sample and stability registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      smp_q <= SMP_RST;
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      smp_q <= smp_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  logic [DIGITS-1:0] sel_c;
  logic [6:0]        seg_c;
  logic [4:0]        dec_c;
  logic              smp_dp_c;

  assign sel_c = ~smp_q[SW-1 -: DIGITS];
  assign seg_c = smp_q[6:0];
  assign dec_c = seg_decode(seg_c);
`ifdef SEG_READER_DP_EN
  assign smp_dp_c = smp_q[7];
`else
  assign smp_dp_c = 1'b0;
`endif

  logic [4*DIGITS-1:0] value_d, value_q;
  logic [DIGITS-1:0]   valid_d, valid_q;
  logic [DIGITS-1:0]   dp_d, dp_q;
  logic                upd_d, upd_q;
  logic [2:0]          upd_idx_d, upd_idx_q;
  logic                err_d, err_q;

  // Commit decision: write/blank a digit, or flag an illegal pattern/select.
  always_comb begin
    value_d   = value_q;
    valid_d   = valid_q;
    dp_d      = dp_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    err_d     = err_q;
    if (bus.err_clr) begin
      err_d = 1'b0;
    end
    if (hit_q && (sel_c != '0)) begin
      if (!$onehot(sel_c)) begin
        err_d = 1'b1;
      end else if (dec_c[4] || (seg_c == 7'h00)) begin
        upd_d = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (sel_c[i]) begin
            if (dec_c[4]) begin
              value_d[4*i +: 4] = dec_c[3:0];
            end
            valid_d[i] = dec_c[4];
            dp_d[i]    = smp_dp_c;
            upd_idx_d  = 3'(i);
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value_q   <= '0;
      valid_q   <= '0;
      dp_q      <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      value_q   <= value_d;
      valid_q   <= valid_d;
      dp_q      <= dp_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      err_q     <= err_d;
    end
  end

  assign bus.value   = value_q;
  assign bus.valid   = valid_q;
  assign bus.upd     = upd_q;
  assign bus.upd_idx = upd_idx_q;
  assign bus.err     = err_q;
`ifdef SEG_READER_DP_EN
  assign bus.dp      = dp_q;
`else
  logic unused_dp_c;
  assign unused_dp_c = ^{dp_q, smp_dp_c};
`endif

endmodule

// File: tb/tb_seg_reader.sv
// Bench for seg_reader: directed scenarios with literal expectations plus a
// randomized scan, all checked every cycle against a run-length reference model.
module tb_seg_reader;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 3;
  localparam int unsigned SMPW   = DIGITS + 8;
`ifdef SEG_READER_DP_EN
  localparam bit DP_ON = 1'b1;
`else
  localparam bit DP_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  seg_reader_if #(.DIGITS(DIGITS)) bus ();

  seg_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   upd_seen = 0;
  logic dp_drv   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] pat_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h6F, 7'h47};

  logic [4*DIGITS-1:0] m_value = '0;
  logic [DIGITS-1:0]   m_valid = '0;
  logic [DIGITS-1:0]   m_dp    = '0;
  logic                m_upd   = 1'b0;
  logic [2:0]          m_idx   = 3'd0;
  logic                m_err   = 1'b0;
  logic [SMPW-1:0]     hist [$];

  logic [SMPW-1:0]   m_s;
  logic [DIGITS-1:0] m_nd;
  logic              m_run;
  int                m_lows, m_dig, m_found;

  // A commit happens when the last STABLE samples are one run that started
  // exactly STABLE edges ago (the first sample after reset always starts a run).
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_value = '0; m_valid = '0; m_dp = '0;
      m_upd = 1'b0; m_idx = 3'd0; m_err = 1'b0;
      hist.delete();
    end else begin
      m_upd = 1'b0;
      if (bus.err_clr) m_err = 1'b0;
      if (hist.size() >= int'(STABLE)) begin
        m_run = 1'b1;
        for (int k = 1; k < int'(STABLE); k++)
          if (hist[hist.size()-1-k] != hist[hist.size()-1]) m_run = 1'b0;
        if (hist.size() > int'(STABLE) && hist[0] == hist[1]) m_run = 1'b0;
        if (m_run) begin
          m_s    = hist[hist.size()-1];
          m_nd   = m_s[SMPW-1 -: DIGITS];
          m_lows = $countones(~m_nd);
          if (m_lows > 1) begin
            m_err = 1'b1;
          end else if (m_lows == 1) begin
            m_dig = 0;
            for (int d = 0; d < int'(DIGITS); d++) if (!m_nd[d]) m_dig = d;
            m_found = -1;
            for (int j = 0; j < 16; j++) if (pat_tab[j] == m_s[6:0]) m_found = j;
            if (m_found >= 0 || m_s[6:0] == 7'h00) begin
              if (m_found >= 0) m_value[4*m_dig +: 4] = 4'(m_found);
              m_valid[m_dig] = (m_found >= 0);
              m_dp[m_dig]    = m_s[7];
              m_upd          = 1'b1;
              m_idx          = 3'(m_dig);
            end else begin
              m_err = 1'b1;
            end
          end
        end
      end
      hist.push_back({bus.n_dig, dp_drv, bus.seg_in});
      if (hist.size() > int'(STABLE) + 1) void'(hist.pop_front());
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (n_rst) begin
      chk("value",   32'(bus.value),   32'(m_value));
      chk("valid",   32'(bus.valid),   32'(m_valid));
      chk("upd",     32'(bus.upd),     32'(m_upd));
      chk("upd_idx", 32'(bus.upd_idx), 32'(m_idx));
      chk("err",     32'(bus.err),     32'(m_err));
`ifdef SEG_READER_DP_EN
      chk("dp",      32'(bus.dp),      32'(m_dp));
`endif
      if (bus.upd) upd_seen++;
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [DIGITS-1:0] IDLE = '1;

  task automatic drv(input logic [DIGITS-1:0] nd, input logic [6:0] sg, input logic dpv,
                     input logic clr);
    bus.n_dig   = nd;
    bus.seg_in  = sg;
    bus.err_clr = clr;
    dp_drv      = DP_ON ? dpv : 1'b0;
`ifdef SEG_READER_DP_EN
    bus.seg_dp  = dp_drv;
`endif
  endtask

  task automatic hold(input logic [DIGITS-1:0] nd, input logic [6:0] sg, input logic dpv,
                      input logic clr, input int n);
    drv(nd, sg, dpv, clr);
    repeat (n) @(negedge clk);
  endtask

  logic [6:0] scan_pat [4] = '{7'h6D, 7'h79, 7'h33, 7'h47};
  int         s0;
  int         r;
  logic [DIGITS-1:0] rnd_nd;
  logic [6:0]        rnd_sg;

  initial begin
    drv(IDLE, 7'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst value",   32'(bus.value),   32'h0);
    chk("rst valid",   32'(bus.valid),   32'h0);
    chk("rst upd",     32'(bus.upd),     32'h0);
    chk("rst upd_idx", 32'(bus.upd_idx), 32'h0);
    chk("rst err",     32'(bus.err),     32'h0);

    // First commit after reset release: upd on the 3rd edge after the first sample.
    n_rst = 1'b1;
    drv(4'b1110, 7'h7E, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1 early upd", 32'(bus.upd), 32'h0);
    @(negedge clk);
    chk("t1 upd",     32'(bus.upd),     32'h1);
    chk("t1 upd_idx", 32'(bus.upd_idx), 32'h0);
    chk("t1 value",   32'(bus.value),   32'h0);
    chk("t1 valid",   32'(bus.valid),   32'h1);
    chk("t1 err",     32'(bus.err),     32'h0);
    hold(IDLE, 7'h00, 1'b0, 1'b0, 1);

    // Four-digit scan with one-clock blanking gaps.
    s0 = upd_seen;
    for (int d = 0; d < 4; d++) begin
      hold(4'b1111 ^ (4'(1) << d), scan_pat[d], 1'b0, 1'b0, 8);
      hold(IDLE, 7'h00, 1'b0, 1'b0, 1);
    end
    chk("scan upd count", 32'(upd_seen - s0), 32'd4);
    chk("scan value",     32'(bus.value),     32'hF432);
    chk("scan valid",     32'(bus.valid),     32'hF);
    chk("scan err",       32'(bus.err),       32'h0);

    // Short glitch must not commit.
    s0 = upd_seen;
    hold(4'b1101, 7'h5B, 1'b0, 1'b0, 2);
    hold(4'b1101, 7'h7B, 1'b0, 1'b0, 4);
    hold(IDLE, 7'h00, 1'b0, 1'b0, 2);
    chk("glitch upd count", 32'(upd_seen - s0), 32'd1);
    chk("glitch value",     32'(bus.value),     32'hF492);

    // Illegal pattern, clear on quiet cycle.
    hold(4'b1101, 7'h7C, 1'b0, 1'b0, 3);
    hold(IDLE, 7'h00, 1'b0, 1'b0, 2);
    chk("illegal err",   32'(bus.err),   32'h1);
    chk("illegal value", 32'(bus.value), 32'hF492);
    chk("illegal valid", 32'(bus.valid), 32'hF);
    hold(IDLE, 7'h00, 1'b0, 1'b1, 1);
    chk("clr err", 32'(bus.err), 32'h0);

    // Two selects low, with err_clr on the same edge as the error: set wins.
    hold(4'b1100, 7'h30, 1'b0, 1'b0, 3);
    hold(4'b1100, 7'h30, 1'b0, 1'b1, 1);
    chk("set wins err", 32'(bus.err), 32'h1);
    hold(IDLE, 7'h00, 1'b0, 1'b0, 2);
    chk("multi value", 32'(bus.value), 32'hF492);
    chk("multi valid", 32'(bus.valid), 32'hF);
    hold(IDLE, 7'h00, 1'b0, 1'b1, 1);

    // Blank on digit 2 clears valid but keeps the nibble.
    hold(4'b1011, 7'h00, 1'b0, 1'b0, 5);
    chk("blank valid",   32'(bus.valid),   32'hB);
    chk("blank value",   32'(bus.value),   32'hF492);
    chk("blank upd_idx", 32'(bus.upd_idx), 32'h2);
    hold(IDLE, 7'h00, 1'b0, 1'b0, 2);

`ifdef SEG_READER_DP_EN
    hold(4'b0111, 7'h5F, 1'b1, 1'b0, 5);
    chk("dp value", 32'(bus.value), 32'h6492);
    chk("dp bit3",  32'(bus.dp[3]), 32'h1);
    hold(IDLE, 7'h00, 1'b0, 1'b0, 2);
`endif

    // Asynchronous reset mid-scan, then a full window before the next commit.
    hold(4'b0111, 7'h33, 1'b0, 1'b0, 2);
    #2 n_rst = 1'b0;
    #1;
    chk("mid rst value",   32'(bus.value),   32'h0);
    chk("mid rst valid",   32'(bus.valid),   32'h0);
    chk("mid rst upd_idx", 32'(bus.upd_idx), 32'h0);
    chk("mid rst err",     32'(bus.err),     32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post rst early upd", 32'(bus.upd), 32'h0);
    @(negedge clk);
    chk("post rst upd",     32'(bus.upd),     32'h1);
    chk("post rst upd_idx", 32'(bus.upd_idx), 32'h3);
    chk("post rst value",   32'(bus.value),   32'h4000);
    chk("post rst valid",   32'(bus.valid),   32'h8);

    // Randomized scan traffic.
    repeat (500) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      rnd_nd = 4'b1111 ^ (4'(1) << $urandom_range(0, DIGITS - 1));
      else if (r <= 7) rnd_nd = IDLE;
      else             rnd_nd = 4'($urandom);
      r = int'($urandom_range(0, 9));
      if (r <= 6)      rnd_sg = pat_tab[$urandom_range(0, 15)];
      else if (r == 7) rnd_sg = 7'h00;
      else             rnd_sg = 7'($urandom);
      hold(rnd_nd, rnd_sg, 1'($urandom), ($urandom_range(0, 5) == 0),
           int'($urandom_range(1, 6)));
    end
    hold(IDLE, 7'h00, 1'b0, 1'b0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_reader.md
Name: seg_reader

Overview:
- Reverse of the team's hex-to-7-segment display driver: samples a scanned, multiplexed 7-segment bus and recovers one 4-bit hex value per digit.
- Used on loopback and self-check paths to read back what the display drivers emit, and to snoop external multiplexed displays.
- A pattern is committed only after it has been stable for a programmable number of clocks.
- Illegal patterns and illegal digit selects raise a sticky error flag.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE, 3, consecutive identical samples required before commit (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- seg_in  input  7  segment bus, active-high; bit6=a, bit5=b ... bit0=g.
- n_dig  input  DIGITS  digit selects, active-low; exactly one low = digit addressed.
- err_clr  input  1  synchronous clear of err.
- value  output  4*DIGITS  recovered nibbles; digit i occupies bits [4i+3:4i].
- valid  output  DIGITS  per-digit flag: holds a decoded hex value.
- upd  output  1  one-cycle pulse on each commit to a digit.
- upd_idx  output  3  digit index of the current upd.
- err  output  1  sticky error.

Behaviour:
- Reset (n_rst low, async): value=0, valid=0, upd=0, upd_idx=0, err=0.
- Reset also sets the sample register to n_dig=all-ones, seg=0, and the stability counter to 0.
- Sampling: each edge registers {n_dig, seg_in}.
  - If the new sample equals the previous sample, the counter increments, saturating at STABLE.
  - Otherwise the counter loads 1.
- Commit: fires on the edge after the counter first reaches STABLE. Holding the pair steady longer does not recommit. Changing away and back re-arms the commit.
- Latency: a pair steady before sampling edge 0 commits at edge STABLE; outputs are visible after edge STABLE.
- Decode table (seg → nibble):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→B, 0D→C, 3D→D, 6F→E, 47→F
- Commit with exactly one n_dig bit low (index i):
  - Table pattern: value[i]=nibble, valid[i]=1, upd=1, upd_idx=i.
  - seg=00 (blank): value[i] unchanged, valid[i]=0, upd=1, upd_idx=i.
  - Any other pattern: err=1; value and valid unchanged; no upd.
- Commit with n_dig all-ones (inter-digit blanking): no action, no error.
- Commit with two or more n_dig bits low: err=1, no write, no upd.
- upd is high exactly one cycle per commit. upd_idx holds its last value when upd=0.
- err_clr and an error event on the same edge: set wins, err stays 1.
- Reset mid-scan: all captured state is lost immediately. The first commit after release needs a full STABLE-sample window.
- Counter width is ceil(log2(STABLE+1)). No wrap-around, since the counter saturates.

Optional Feature:
- Macro SEG_READER_DP_EN.
- Defined:
  - Adds input seg_dp (1 bit, active-high decimal point) and output dp (DIGITS bits).
  - seg_dp is part of the sampled and compared pair.
  - On a valid or blank commit to digit i, dp[i]=seg_dp. dp resets to 0.
- Not defined: no seg_dp/dp ports; behaviour otherwise identical.

Test Plan:
- Reset release, STABLE=3: n_dig=4'b1110, seg=7E held → upd pulses at 3rd edge after first sample, upd_idx=0, value[3:0]=0, valid=4'b0001, err=0.
- Scan 4 digits at 8 clocks/digit with 1-clock all-ones gaps, patterns 6D,79,33,47 → value=16'hF432, valid=4'b1111, four upd pulses, err=0.
- Glitch: seg=5B for 2 clocks then 7B on the same digit for 4 clocks → only 9 committed, one upd.
- Illegal: n_dig=4'b1101 with seg=7C held 3 clocks → err=1, value/valid unchanged; err_clr on a quiet cycle → err=0. err_clr on the same edge as a new error → err stays 1.
- n_dig=4'b1100 with seg=30 → err=1, no write. Blank seg=00 on digit 2 → valid[2]=0, value[11:8] kept, upd_idx=2.
- With SEG_READER_DP_EN: seg=5F, seg_dp=1 on digit 3 → value[15:12]=6, dp[3]=1. Async reset mid-scan → all outputs 0 immediately.
